// File: rtl/exe_stage_mc.sv
// ARM execute stage: forwarding, shifter, ALU, branch target and an optional
// iterative radix-2 multiplier. All results are registered and qualified by out_valid.
module exe_stage_mc #(
  parameter int DATA_W = 32,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [3:0]        EXE_CMD,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              mul,
  input  logic              acc,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Val_Rn,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [DATA_W-1:0] Val_Ra,
  input  logic              imm,
  input  logic [11:0]       Shift_operand,
  input  logic [23:0]       Signed_imm_24,
  input  logic [3:0]        SR,
  input  logic [DATA_W-1:0] MEM_ALU_Res,
  input  logic [DATA_W-1:0] WB_Value,
  input  logic [1:0]        Sel_src1,
  input  logic [1:0]        Sel_src2,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Br_addr,
  output logic [DATA_W-1:0] ST_Val,
  output logic [3:0]        status,
  output logic              out_valid,
  output logic              stall
);
  // state  | meaning
  // S_IDLE | ready; single-cycle ops complete from here
  // S_MUL  | shift-add iteration cnt_q in progress, stall high

  localparam int         SW      = $clog2(DATA_W);
  localparam int         M       = DATA_W - 1;
  localparam bit         HAS_MUL = (MUL_EN != 0);
  localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                         CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                         CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state_q, state_d;

  logic [SW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, macc_q, macc_d;
  logic [1:0]        mcv_q, mcv_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d, br_q, br_d, st_q, st_d;
  logic [3:0]        status_q, status_d;
  logic              valid_q, valid_d;

  logic              accept, is_mul, last_iter, known;
  logic [3:0]        eff_cmd, alu_flags;
  logic [DATA_W-1:0] op1, fwd2, val2, res, br_tgt;
  logic signed [DATA_W-1:0] fwd2_s;
  logic [DATA_W:0]   sum;
  logic [SW-1:0]     sh_amt, rot_amt;
  logic              c_f, v_f;
  logic signed [25:0] br_off;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                            input logic [SW-1:0] amt);
    return (x >> amt) | (x << (DATA_W - int'(amt)));
  endfunction

  assign is_mul    = mul & HAS_MUL;
  assign eff_cmd   = (mul & ~HAS_MUL) ? CMD_MOV : EXE_CMD;
  assign accept    = in_valid & ~stall & ~flush & rst;
  assign last_iter = (cnt_q == SW'(DATA_W - 1));

  always_comb begin
    case (Sel_src1)
      2'b01:   op1 = MEM_ALU_Res;
      2'b10:   op1 = WB_Value;
      default: op1 = Val_Rn;
    endcase
    case (Sel_src2)
      2'b01:   fwd2 = MEM_ALU_Res;
      2'b10:   fwd2 = WB_Value;
      default: fwd2 = Val_Rm;
    endcase
  end

  // Shift/rotate amounts are reduced mod DATA_W by truncation (DATA_W is a power of two)
  always_comb begin
    sh_amt  = SW'(Shift_operand[11:7]);
    rot_amt = SW'({Shift_operand[11:8], 1'b0});
    fwd2_s  = fwd2;
    if (MEM_R_EN | MEM_W_EN) begin
      val2 = DATA_W'(Shift_operand);
    end else if (imm) begin
      val2 = ror(DATA_W'(Shift_operand[7:0]), rot_amt);
    end else begin
      case (Shift_operand[6:5])
        2'b00:   val2 = fwd2 << sh_amt;
        2'b01:   val2 = fwd2 >> sh_amt;
        2'b10:   val2 = fwd2_s >>> sh_amt;
        default: val2 = ror(fwd2, sh_amt);
      endcase
    end
  end

  always_comb begin
    sum   = '0;
    res   = '0;
    c_f   = SR[1];
    v_f   = SR[0];
    known = 1'b1;
    case (eff_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, (eff_cmd == CMD_ADC) & SR[1]};
        res = sum[M:0];
        c_f = sum[DATA_W];
        v_f = (op1[M] == val2[M]) && (res[M] != op1[M]);
      end
      CMD_SUB, CMD_SBC: begin
        // subtract as op1 + ~val2 + cin so carry out reads as "no borrow"
        sum = {1'b0, op1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, (eff_cmd == CMD_SUB) | SR[1]};
        res = sum[M:0];
        c_f = sum[DATA_W];
        v_f = (op1[M] != val2[M]) && (res[M] != op1[M]);
      end
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      default: known = 1'b0;
    endcase
    alu_flags = known ? {res[M], res == '0, c_f, v_f} : SR;
  end

  always_comb begin
    br_off = {Signed_imm_24, 2'b00};
    br_tgt = PC + DATA_W'(br_off);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (flush || last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = (state_q == S_MUL);
  end

  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    macc_d    = macc_q;
    mcv_d     = mcv_q;
    alu_res_d = alu_res_q;
    br_d      = br_q;
    st_d      = st_q;
    status_d  = status_q;
    valid_d   = 1'b0;
    if (state_q == S_MUL) begin
      macc_d   = macc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SW'(1);
      if (flush) begin
        cnt_d = '0;
      end else if (last_iter) begin
        cnt_d     = '0;
        alu_res_d = macc_d;
        status_d  = {macc_d[M], macc_d == '0, mcv_q};
        valid_d   = 1'b1;
      end
    end else if (accept) begin
      if (is_mul) begin
        mcand_d  = op1;
        mplier_d = fwd2;
        macc_d   = acc ? Val_Ra : '0;
        mcv_d    = SR[1:0];
        cnt_d    = '0;
      end else begin
        alu_res_d = res;
        status_d  = alu_flags;
        br_d      = br_tgt;
        st_d      = fwd2;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      macc_q    <= '0;
      mcv_q     <= '0;
      alu_res_q <= '0;
      br_q      <= '0;
      st_q      <= '0;
      status_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      macc_q    <= macc_d;
      mcv_q     <= mcv_d;
      alu_res_q <= alu_res_d;
      br_q      <= br_d;
      st_q      <= st_d;
      status_q  <= status_d;
      valid_q   <= valid_d;
    end
  end

  assign ALU_result = alu_res_q;
  assign Br_addr    = br_q;
  assign ST_Val     = st_q;
  assign status     = status_q;
  assign out_valid  = valid_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: a 32-bit and a 16-bit instance share stimulus and are
// compared every cycle against an arithmetic reference model, plus directed literal checks.
module tb_exe_stage_mc;
  typedef longint unsigned u64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, MEM_R_EN, MEM_W_EN, mul, acc, imm;
  logic [3:0]  EXE_CMD, SR;
  logic [31:0] PC, Val_Rn, Val_Rm, Val_Ra, MEM_ALU_Res, WB_Value;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [1:0]  Sel_src1, Sel_src2;

  logic [31:0] alu32, br32, st32;
  logic [3:0]  fl32;
  logic        ov32, stall32;
  logic [15:0] alu16, br16, st16;
  logic [3:0]  fl16;
  logic        ov16, stall16;

  exe_stage_mc #(.DATA_W(32), .MUL_EN(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .EXE_CMD(EXE_CMD),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .mul(mul), .acc(acc), .PC(PC),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Ra(Val_Ra), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .SR(SR),
    .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value), .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
    .ALU_result(alu32), .Br_addr(br32), .ST_Val(st32), .status(fl32),
    .out_valid(ov32), .stall(stall32));

  exe_stage_mc #(.DATA_W(16), .MUL_EN(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .EXE_CMD(EXE_CMD),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .mul(mul), .acc(acc), .PC(PC[15:0]),
    .Val_Rn(Val_Rn[15:0]), .Val_Rm(Val_Rm[15:0]), .Val_Ra(Val_Ra[15:0]), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .SR(SR),
    .MEM_ALU_Res(MEM_ALU_Res[15:0]), .WB_Value(WB_Value[15:0]),
    .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
    .ALU_result(alu16), .Br_addr(br16), .ST_Val(st16), .status(fl16),
    .out_valid(ov16), .stall(stall16));

  typedef struct {
    u64 alu; u64 br; u64 st; logic [3:0] fl;
    bit valid; bit sc; int busy; u64 mres; logic [3:0] mfl;
  } mdl_t;

  mdl_t md [2];
  int   wid [2] = '{32, 16};
  int   total = 0, bad = 0;
  bit   chk_en = 1'b0;

  task automatic chk(string name, u64 act, u64 exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic u64 msk(int w);
    return (u64'(1) << w) - 1;
  endfunction

  function automatic longint sx(u64 x, int w);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  function automatic u64 rotr(u64 x, int a, int w);
    if (a == 0) return x;
    return ((x >> a) | (x << (w - a))) & msk(w);
  endfunction

  function automatic bit ovf(longint v, int w);
    return (v > ((longint'(1) << (w - 1)) - 1)) || (v < -(longint'(1) << (w - 1)));
  endfunction

  function automatic u64 fwd(logic [1:0] s, u64 r, u64 mem, u64 wb, int w);
    case (s)
      2'b01:   return mem & msk(w);
      2'b10:   return wb & msk(w);
      default: return r & msk(w);
    endcase
  endfunction

  function automatic u64 val2_f(int w, bit memop, bit im, logic [11:0] so, u64 f2);
    int a;
    if (memop) return u64'(so);
    if (im) return rotr(u64'(so[7:0]), (2 * int'(so[11:8])) % w, w);
    a = int'(so[11:7]) % w;
    case (so[6:5])
      2'b00:   return (f2 << a) & msk(w);
      2'b01:   return f2 >> a;
      2'b10:   return u64'(sx(f2, w) >>> a) & msk(w);
      default: return rotr(f2, a, w);
    endcase
  endfunction

  function automatic void alu_f(int w, logic [3:0] cmd, u64 a, u64 b, logic [3:0] sr,
                                output u64 r, output logic [3:0] fl);
    longint sa, sb;
    u64 m, cin;
    bit c, v;
    sa = sx(a, w); sb = sx(b, w); m = msk(w); cin = u64'(sr[1]);
    c = sr[1]; v = sr[0];
    r = 0; fl = sr;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b & m;
      4'b0010: begin r = (a + b) & m; c = ((a + b) >> w) != 0; v = ovf(sa + sb, w); end
      4'b0011: begin
        r = (a + b + cin) & m; c = ((a + b + cin) >> w) != 0; v = ovf(sa + sb + longint'(cin), w);
      end
      4'b0100: begin r = (a - b) & m; c = (a >= b); v = ovf(sa - sb, w); end
      4'b0101: begin
        r = (a - b - (1 - cin)) & m; c = (a >= b + (1 - cin));
        v = ovf(sa - sb - longint'(1 - cin), w);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: return;
    endcase
    fl = {r[w-1], r == 0, c, v};
  endfunction

  function automatic u64 br_f(int w, u64 pc, logic [23:0] off);
    return (pc + u64'(sx(u64'(off), 24) * 4)) & msk(w);
  endfunction

  task automatic model_step(int k);
    int w;
    u64 m, o1, f2, r;
    logic [3:0] fl;
    w = wid[k]; m = msk(w);
    if (!rst) begin
      md[k] = '{default: '0};
      return;
    end
    if (md[k].busy > 0) begin
      md[k].valid = 1'b0;
      if (flush) md[k].busy = 0;
      else begin
        md[k].busy--;
        if (md[k].busy == 0) begin
          md[k].alu = md[k].mres; md[k].fl = md[k].mfl; md[k].valid = 1'b1; md[k].sc = 1'b0;
        end
      end
    end else if (in_valid && !flush) begin
      o1 = fwd(Sel_src1, Val_Rn, MEM_ALU_Res, WB_Value, w);
      f2 = fwd(Sel_src2, Val_Rm, MEM_ALU_Res, WB_Value, w);
      if (mul) begin
        r = (o1 * f2 + (acc ? (u64'(Val_Ra) & m) : 0)) & m;
        md[k].mres = r; md[k].mfl = {r[w-1], r == 0, SR[1:0]};
        md[k].busy = w; md[k].valid = 1'b0;
      end else begin
        alu_f(w, EXE_CMD, o1, val2_f(w, MEM_R_EN || MEM_W_EN, imm, Shift_operand, f2), SR, r, fl);
        md[k].alu = r; md[k].fl = fl; md[k].br = br_f(w, PC, Signed_imm_24);
        md[k].st = f2; md[k].valid = 1'b1; md[k].sc = 1'b1;
      end
    end else begin
      md[k].valid = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid32", ov32, md[0].valid);
      chk("stall32", stall32, md[0].busy > 0);
      chk("alu32", alu32, md[0].alu);
      chk("flags32", fl32, md[0].fl);
      if (md[0].valid && md[0].sc) begin
        chk("br32", br32, md[0].br);
        chk("st32", st32, md[0].st);
      end
      chk("valid16", ov16, md[1].valid);
      chk("stall16", stall16, md[1].busy > 0);
      chk("alu16", alu16, md[1].alu);
      chk("flags16", fl16, md[1].fl);
      if (md[1].valid && md[1].sc) begin
        chk("br16", br16, md[1].br);
        chk("st16", st16, md[1].st);
      end
    end
  end

  task automatic clear_in();
    in_valid = 0; flush = 0; MEM_R_EN = 0; MEM_W_EN = 0; mul = 0; acc = 0; imm = 0;
    EXE_CMD = 4'b0001; SR = 4'b0000; PC = 0; Val_Rn = 0; Val_Rm = 0; Val_Ra = 0;
    MEM_ALU_Res = 0; WB_Value = 0; Shift_operand = 0; Signed_imm_24 = 0;
    Sel_src1 = 0; Sel_src2 = 0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_alu32"}, alu32, 0);   chk({tag, "_br32"}, br32, 0);
    chk({tag, "_st32"}, st32, 0);     chk({tag, "_flags32"}, fl32, 0);
    chk({tag, "_valid32"}, ov32, 0);  chk({tag, "_stall32"}, stall32, 0);
    chk({tag, "_alu16"}, alu16, 0);   chk({tag, "_valid16"}, ov16, 0);
    chk({tag, "_stall16"}, stall16, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((stall32 || stall16) && n < 100) begin n++; tick(); end
    chk("idle_timeout", n < 100, 1);
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_8000;
      5: return 32'h0000_7FFF;
      default: return $urandom();
    endcase
  endfunction

  logic [3:0] cmds [9] = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  initial begin
    int  n;
    bit  saw;
    clear_in();
    rst = 0;
    tick(); tick();
    check_zero("reset");
    chk_en = 1;
    rst = 1;

    in_valid = 1; Val_Rn = 5; Sel_src1 = 2'b01; MEM_ALU_Res = 32'h10; imm = 1;
    Shift_operand = 12'h003; EXE_CMD = 4'b0010;
    tick();
    chk("add_fwd_res", alu32, 32'h13);
    chk("add_fwd_valid", ov32, 1);

    Val_Rn = 3; Sel_src1 = 2'b00; Shift_operand = 12'h005; EXE_CMD = 4'b0100;
    tick();
    chk("sub_res", alu32, 32'hFFFF_FFFE);
    chk("sub_flags", fl32, 4'b1000);
    chk("sub16_res", alu16, 16'hFFFE);

    Shift_operand = 12'hCFF; EXE_CMD = 4'b0001;
    tick();
    chk("mov_rot32", alu32, 32'h0000_FF00);
    chk("mov_rot16", alu16, 16'hFF00);

    imm = 0; Val_Rm = 32'h8000_0000; Shift_operand = 12'h240;
    tick();
    chk("asr4", alu32, 32'hF800_0000);

    PC = 32'h100; Signed_imm_24 = 24'hFFFFFE; EXE_CMD = 4'b0010;
    tick();
    chk("br16_addr", br16, 16'h00F8);
    chk("br32_addr", br32, 32'h0000_00F8);
    chk("st_val", st32, 32'h8000_0000);

    in_valid = 0;
    tick();
    chk("idle_valid", ov32, 0);
    chk("idle_hold", alu32, 32'hF800_0003);

    clear_in();
    in_valid = 1; mul = 1; acc = 1; Val_Rn = 7; Val_Rm = 6; Val_Ra = 3;
    tick();
    chk("mla_valid_low", ov32, 0);
    mul = 0; acc = 0; EXE_CMD = 4'b0001;
    n = 0;
    while (stall32 && n < 100) begin
      Sel_src1 = 2'($urandom_range(0, 3)); Sel_src2 = 2'($urandom_range(0, 3));
      MEM_ALU_Res = $urandom(); WB_Value = $urandom(); Val_Rn = $urandom(); Val_Ra = $urandom();
      n++;
      tick();
    end
    chk("mla_stall_cycles", n, 32);
    chk("mla_res", alu32, 45);
    chk("mla_valid", ov32, 1);
    clear_in();
    tick();
    wait_idle();

    in_valid = 1; mul = 1; Val_Rn = 32'h0100; Val_Rm = 32'h0100; SR = 4'b0000;
    tick();
    clear_in();
    n = 0;
    while (stall16 && n < 100) begin n++; tick(); end
    chk("mul16_latency", n + 1, 17);
    chk("mul16_res", alu16, 16'h0000);
    chk("mul16_flags", fl16, 4'b0100);
    chk("mul16_valid", ov16, 1);
    wait_idle();

    in_valid = 1; mul = 1; Val_Rn = 3; Val_Rm = 5;
    tick();
    clear_in();
    repeat (10) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_stall32", stall32, 0);
    chk("flush_valid32", ov32, 0);
    chk("flush_stall16", stall16, 0);
    saw = 0;
    repeat (40) begin tick(); saw |= ov32 | ov16; end
    chk("flush_no_result", saw, 0);

    in_valid = 1; mul = 1; acc = 1; Val_Rn = 11; Val_Rm = 13; Val_Ra = 1;
    tick();
    clear_in();
    repeat (5) tick();
    rst = 0;
    tick();
    check_zero("rst_mul");
    rst = 1;
    saw = 0;
    repeat (40) begin tick(); saw |= ov32 | ov16; end
    chk("rst_no_result", saw, 0);

    repeat (3000) begin
      rst = ($urandom_range(0, 399) != 0);
      in_valid = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 29) == 0);
      mul = ($urandom_range(0, 7) == 0);
      acc = 1'($urandom_range(0, 1));
      MEM_R_EN = ($urandom_range(0, 7) == 0);
      MEM_W_EN = ($urandom_range(0, 7) == 0);
      imm = 1'($urandom_range(0, 1));
      EXE_CMD = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 8)];
      SR = 4'($urandom());
      PC = $urandom(); Val_Rn = rv(); Val_Rm = rv(); Val_Ra = rv();
      MEM_ALU_Res = rv(); WB_Value = rv();
      Shift_operand = 12'($urandom()); Signed_imm_24 = 24'($urandom());
      Sel_src1 = 2'($urandom_range(0, 3)); Sel_src2 = 2'($urandom_range(0, 3));
      tick();
    end
    clear_in();
    rst = 1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
